tile_row_streamer: RTL
======================

Name: tile_row_streamer

Overview:
- Downstream drain stage for the inference pipeline.
- Captures each post-processed int8 4x4 tile (the quantized result bus, plus its done pulse) into a 2-entry ping-pong buffer.
- Streams each tile out one row per beat over a valid/ready interface, toward the output memory or host link.
- Exposes back-pressure (tile_ready) so the pipeline controller can hold off the next start while both buffer slots are occupied.

Parameters:
- N, 4, tile dimension (rows = columns = N).
- DATA_WIDTH, 8, bits per quantized element.
- ROW_IDX_W, 2, width of the row index; must equal clog2(N).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- tile_valid  input  1  single-cycle pulse: tile_data holds a complete tile.
- tile_data  input  N*N*DATA_WIDTH  row-major tile; element (i,j) at bits [(i*N+j)*DATA_WIDTH +: DATA_WIDTH].
- tile_ready  output  1  high when at least one buffer slot is free.
- out_valid  output  1  a row beat is presented.
- out_ready  input  1  consumer accepts the beat.
- out_data  output  N*DATA_WIDTH  row r of the head tile: tile bits [r*N*DATA_WIDTH +: N*DATA_WIDTH].
- out_row  output  ROW_IDX_W  index of the row currently presented.
- out_last  output  1  high with the final row (out_row == N-1) of a tile.
- occupancy  output  2  tiles held, 0..2.
- overflow  output  1  sticky: a tile arrived while the buffer was full.
- clear_overflow  input  1  clears overflow.

Behaviour:
- Interface: one clock; reset is synchronous and active-high (clk, rst).
- Reset values: occupancy=0, wr_ptr=0, rd_ptr=0, row_idx=0, overflow=0. All outputs are 0 and tile_ready=1.
- Buffer storage is not reset.
- Derived outputs:
  - tile_ready = (occupancy < 2), computed from registered state only.
  - out_valid = (occupancy > 0).
  - out_row = row_idx.
  - out_last = out_valid && (row_idx == N-1).
  - out_data is driven from buf[rd_ptr] at row row_idx; forced to 0 when out_valid=0.
- Capture:
  - When tile_valid && tile_ready at an edge, write buf[wr_ptr] and toggle wr_ptr.
  - out_valid rises in the next cycle if the buffer was empty, giving 1-cycle latency.
- Drop:
  - When tile_valid && !tile_ready, do not write; set overflow=1.
  - overflow stays set until clear_overflow. If set and clear coincide, set wins.
- Beat handshake:
  - A beat transfers on out_valid && out_ready.
  - If row_idx < N-1, row_idx increments.
  - If row_idx == N-1, row_idx goes to 0, rd_ptr toggles and the tile is retired.
- Beat hold: out_valid, once high, stays high with out_data/out_row unchanged until the handshake. Data changes only on a transfer or a capture into an empty buffer.
- Occupancy update:
  - Capture only: +1.
  - Retire only: -1.
  - Capture and retire in the same cycle: unchanged.
  - When occupancy == 2, a simultaneous retire does not make tile_ready high in that cycle (no bypass), so that tile is dropped.
- Throughput: back-to-back tiles with out_ready held high give N beats per tile with no bubbles.
- Wrap-around: wr_ptr and rd_ptr are 1-bit and toggle modulo 2.
- Reset mid-stream: rst on any edge discards all buffered tiles and any partial row progress. The cycle after reset shows out_valid=0.
- out_ready while out_valid=0 is ignored.

Optional Feature:
- Macro: TILE_ROW_STREAMER_STATS_EN.
- With the macro defined, two extra outputs are added:
  - tiles_sent [15:0]: increments on each retire.
  - stall_cycles [15:0]: increments each cycle with out_valid && !out_ready.
  - Both saturate at 16'hFFFF, reset to 0 on rst, and also clear on clear_overflow.
- Without the macro, these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Single tile: tile_data elements = 0x00..0x0F, out_ready=1.
  - Expect 4 beats starting 1 cycle after capture.
  - out_data = 0x03020100, 0x07060504, 0x0B0A0908, 0x0F0E0D0C.
  - out_last only on beat 4; occupancy back to 0 after beat 4.
- Back-pressure: out_ready=0 for 5 cycles after capture.
  - out_valid=1, out_row=0, out_data stable throughout.
  - Raising out_ready then gives 4 consecutive beats.
- Fill and drop: 3 tiles pulsed with out_ready=0.
  - tile_ready falls after the 2nd tile; the 3rd is dropped; overflow=1.
  - Drain yields tiles 1 and 2 only, in order.
  - clear_overflow then returns overflow to 0.
- Simultaneous capture and retire: occupancy=1, tile_valid pulsed on the cycle of the last-row handshake.
  - occupancy stays 1.
  - The next beat is row 0 of the new tile.
- Reset mid-stream: rst asserted after beat 2 of tile 1, with tile 2 buffered.
  - Next cycle: out_valid=0, occupancy=0, overflow=0.
  - A new tile then streams from row 0.
- TILE_ROW_STREAMER_STATS_EN defined: 2 tiles streamed with out_ready low for 3 cycles total.
  - tiles_sent=2, stall_cycles=3.

Source files
------------

// File: rtl/tile_row_streamer.sv
// tile_row_streamer: drain stage that captures quantized NxN int8 tiles into a
// 2-entry ping-pong buffer and streams them out one row per valid/ready beat.
// Optional statistics counters (tiles_sent, stall_cycles) are built only when
// TILE_ROW_STREAMER_STATS_EN is defined.
module tile_row_streamer #(
  parameter int unsigned N          = 4,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ROW_IDX_W  = 2
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        tile_valid,
  input  logic [N*N*DATA_WIDTH-1:0]   tile_data,
  output logic                        tile_ready,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [N*DATA_WIDTH-1:0]     out_data,
  output logic [ROW_IDX_W-1:0]        out_row,
  output logic                        out_last,
  output logic [1:0]                  occupancy,
  output logic                        overflow,
  input  logic                        clear_overflow
`ifdef TILE_ROW_STREAMER_STATS_EN
  ,
  output logic [15:0]                 tiles_sent,
  output logic [15:0]                 stall_cycles
`endif
);

  localparam int unsigned ROW_W    = N * DATA_WIDTH;
  localparam int unsigned TILE_W   = N * ROW_W;
  localparam int unsigned LAST_ROW = N - 1;
  localparam int unsigned CNT_W    = 16;

  // Ping-pong tile storage; contents are don't-care until written.
  logic [TILE_W-1:0]    tile_buf_q [2];

  logic [1:0]           occ_q,      occ_d;
  logic                 wr_ptr_q,   wr_ptr_d;
  logic                 rd_ptr_q,   rd_ptr_d;
  logic [ROW_IDX_W-1:0] row_q,      row_d;
  logic                 ovf_q,      ovf_d;

  logic                 capture;
  logic                 drop;
  logic                 xfer;
  logic                 retire;
  logic                 at_last_row;
  logic [ROW_W-1:0]     head_row;

  // Handshake decode from registered state (no ready bypass on retire).
  always_comb begin
    tile_ready  = (occ_q < 2'd2);
    out_valid   = (occ_q != 2'd0);
    at_last_row = (row_q == ROW_IDX_W'(LAST_ROW));
    capture     = tile_valid && tile_ready;
    drop        = tile_valid && !tile_ready;
    xfer        = out_valid && out_ready;
    retire      = xfer && at_last_row;
  end

  // Row mux from the head slot; data bus is quiet while nothing is presented.
  always_comb begin
    head_row = tile_buf_q[rd_ptr_q][32'(row_q) * ROW_W +: ROW_W];
    out_data = out_valid ? head_row : '0;
    out_row  = row_q;
    out_last = out_valid && at_last_row;
    occupancy = occ_q;
    overflow  = ovf_q;
  end

  // Next-state for pointers, row index, occupancy and sticky overflow.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    row_d    = row_q;
    occ_d    = occ_q;
    ovf_d    = ovf_q;

    if (capture) begin
      wr_ptr_d = ~wr_ptr_q;
    end

    if (xfer) begin
      if (at_last_row) begin
        row_d    = '0;
        rd_ptr_d = ~rd_ptr_q;
      end else begin
        row_d    = row_q + ROW_IDX_W'(1);
      end
    end

    case ({capture, retire})
      2'b10:   occ_d = occ_q + 2'd1;
      2'b01:   occ_d = occ_q - 2'd1;
      default: occ_d = occ_q;
    endcase

    // A drop in the same cycle as a clear keeps the flag set.
    if (drop) begin
      ovf_d = 1'b1;
    end else if (clear_overflow) begin
      ovf_d = 1'b0;
    end
  end

  // Control state register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      occ_q    <= 2'd0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      row_q    <= '0;
      ovf_q    <= 1'b0;
    end else begin
      occ_q    <= occ_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      row_q    <= row_d;
      ovf_q    <= ovf_d;
    end
  end

  // Tile capture into the free slot; storage is intentionally not reset.
  always_ff @(posedge clk) begin
    if (capture && !rst) begin
      tile_buf_q[wr_ptr_q] <= tile_data;
    end
  end

`ifdef TILE_ROW_STREAMER_STATS_EN
  logic [CNT_W-1:0] sent_q,  sent_d;
  logic [CNT_W-1:0] stall_q, stall_d;

  // Saturating counters for retired tiles and back-pressured cycles.
  always_comb begin
    sent_d  = sent_q;
    stall_d = stall_q;
    if (clear_overflow) begin
      sent_d  = '0;
      stall_d = '0;
    end else begin
      if (retire && (sent_q != {CNT_W{1'b1}})) begin
        sent_d = sent_q + CNT_W'(1);
      end
      if (out_valid && !out_ready && (stall_q != {CNT_W{1'b1}})) begin
        stall_d = stall_q + CNT_W'(1);
      end
    end
  end

  // Statistics register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      sent_q  <= '0;
      stall_q <= '0;
    end else begin
      sent_q  <= sent_d;
      stall_q <= stall_d;
    end
  end

  assign tiles_sent   = sent_q;
  assign stall_cycles = stall_q;
`endif

endmodule
